// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Ports: IF_* and DM_* request/ack pairs, MEM_* shared-memory port, BUSY, OWNER_DM.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_ACK,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              OWNER_DM
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_dm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [3:0]        r_cnt;
  logic              w_start;
  logic              w_grant_dm;
  logic              w_last;
  logic              w_busy;

  assign w_start    = IF_REQ | DM_REQ;
  // on a tie, the side that did not win last time gets the bus
  assign w_grant_dm = DM_REQ & (~IF_REQ | ~r_last_dm);
  assign w_last     = (r_cnt == 4'd1);
  assign w_busy     = (r_state != IDLE);

  assign BUSY     = w_busy;
  assign OWNER_DM = w_busy & r_owner;
  assign IF_RDATA = r_if_rdata;
  assign DM_RDATA = r_dm_rdata;

  always_comb begin
    w_next    = r_state;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    MEM_WR    = 1'b0;
    IF_ACK    = 1'b0;
    DM_ACK    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = ACCESS;
      end
      ACCESS: begin
        MEM_ADDR  = r_addr;
        MEM_WDATA = r_wdata;
        // write strobe only while the counter still holds its load value
        MEM_WR    = r_we & (r_cnt == LAT);
        if (w_last) w_next = RESP;
      end
      RESP: begin
        IF_ACK = ~r_owner;
        DM_ACK = r_owner;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last_dm  <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_owner   <= w_grant_dm;
            r_last_dm <= w_grant_dm;
            r_we      <= w_grant_dm & DM_WE;
            r_addr    <= w_grant_dm ? DM_ADDR : IF_ADDR;
            r_wdata   <= w_grant_dm ? DM_WDATA : '0;
            r_cnt     <= LAT;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last && !r_we) begin
            if (r_owner) r_dm_rdata <= MEM_RDATA;
            else         r_if_rdata <= MEM_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Two instances: MEM_LAT=1 (a_*) and MEM_LAT=3 (b_*).
module tb_mem_arbiter;

  typedef struct {
    bit          dm;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [63:0] exp_wr_addr;
  logic [63:0] exp_wr_data;

  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic        a_mem_wr, a_busy, a_owner;
  logic [63:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata;
  logic [63:0] a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic        b_mem_wr, b_busy, b_owner;
  logic [63:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata;
  logic [63:0] b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_a (
    .CLK(clk), .RST(rst_n),
    .IF_REQ(a_if_req), .IF_ADDR(a_if_addr),
    .IF_ACK(a_if_ack), .IF_RDATA(a_if_rdata),
    .DM_REQ(a_dm_req), .DM_WE(a_dm_we),
    .DM_ADDR(a_dm_addr), .DM_WDATA(a_dm_wdata),
    .DM_ACK(a_dm_ack), .DM_RDATA(a_dm_rdata),
    .MEM_ADDR(a_mem_addr), .MEM_WDATA(a_mem_wdata),
    .MEM_WR(a_mem_wr), .MEM_RDATA(a_mem_rdata),
    .BUSY(a_busy), .OWNER_DM(a_owner)
  );

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_b (
    .CLK(clk), .RST(rst_n),
    .IF_REQ(b_if_req), .IF_ADDR(b_if_addr),
    .IF_ACK(b_if_ack), .IF_RDATA(b_if_rdata),
    .DM_REQ(b_dm_req), .DM_WE(b_dm_we),
    .DM_ADDR(b_dm_addr), .DM_WDATA(b_dm_wdata),
    .DM_ACK(b_dm_ack), .DM_RDATA(b_dm_rdata),
    .MEM_ADDR(b_mem_addr), .MEM_WDATA(b_mem_wdata),
    .MEM_WR(b_mem_wr), .MEM_RDATA(b_mem_rdata),
    .BUSY(b_busy), .OWNER_DM(b_owner)
  );

  logic [63:0] mem_a [0:127];
  bit          mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= 64'h0;
      mem_a[8] <= 64'h00A00093;
      mem_init <= 1'b1;
    end else if (a_mem_wr) begin
      mem_a[a_mem_addr[9:3]] <= a_mem_wdata;
    end
  end
  assign a_mem_rdata = mem_a[a_mem_addr[9:3]];
  assign b_mem_rdata = {b_mem_addr[31:0], 32'hC0FFEE00};

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  logic [63:0] mon_a_d;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_mem_wr) begin
        wr_cnt++;
        check("wr_addr", a_mem_addr, exp_wr_addr);
        check("wr_data", a_mem_wdata, exp_wr_data);
      end
      if (a_if_ack || a_dm_ack) begin
        check("one_ack", 64'(a_if_ack & a_dm_ack), 64'h0);
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_extra_ack: got ack at cyc %0d want none",
                   cyc);
        end else begin
          exp_t e;
          e = qa.pop_front();
          mon_a_d = e.dm ? a_dm_rdata : a_if_rdata;
          check("a_port", 64'(a_dm_ack), 64'(e.dm));
          check("a_owner", 64'(a_owner), 64'(e.dm));
          check("a_rdata", mon_a_d, e.data);
          check("a_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b_if_ack || b_dm_ack) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_extra_ack: got ack at cyc %0d want none",
                   cyc);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_port", 64'(b_dm_ack), 64'(e.dm));
          check("b_rdata", b_dm_rdata, e.data);
          check("b_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_a(bit dm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm ? a_dm_ack : a_if_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 64'(got), 64'h1);
  endtask

  // called at a negedge with u_a idle: grant at next edge,
  // ack one cycle later
  task automatic issue_a(bit dm, bit we, logic [63:0] addr,
                         logic [63:0] wd, logic [63:0] want);
    exp_t e;
    e.dm   = dm;
    e.data = want;
    e.cyc  = cyc + 2;
    qa.push_back(e);
    if (dm) begin
      a_dm_req   = 1'b1;
      a_dm_we    = we;
      a_dm_addr  = addr;
      a_dm_wdata = wd;
    end else begin
      a_if_req  = 1'b1;
      a_if_addr = addr;
    end
    wait_a(dm);
    a_if_req = 1'b0;
    a_dm_req = 1'b0;
    a_dm_we  = 1'b0;
  endtask

  initial begin
    int n;
    exp_t e;
    rst_n = 1'b0;
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0;
    a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0;
    b_dm_addr = 0; b_dm_wdata = 0;
    exp_wr_addr = 0; exp_wr_data = 0;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(a_busy), 64'h0);
    check("rst_owner", 64'(a_owner), 64'h0);
    check("rst_wr", 64'(a_mem_wr), 64'h0);
    check("rst_addr", a_mem_addr, 64'h0);
    check("rst_wdata", a_mem_wdata, 64'h0);
    check("rst_if_rd", a_if_rdata, 64'h0);
    check("rst_dm_rd", a_dm_rdata, 64'h0);
    check("rst_b_busy", 64'(b_busy), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue_a(0, 0, 64'h40, 0, 64'h00A00093);
    @(negedge clk);
    check("fetch_no_wr", 64'(wr_cnt), 64'h0);
    check("idle_addr", a_mem_addr, 64'h0);
    check("idle_owner", 64'(a_owner), 64'h0);
    check("idle_busy", 64'(a_busy), 64'h0);

    exp_wr_addr = 64'h100;
    exp_wr_data = 64'hDEADBEEF;
    issue_a(1, 1, 64'h100, 64'hDEADBEEF, 64'h0);
    @(negedge clk);
    check("store_wr_cnt", 64'(wr_cnt), 64'h1);

    issue_a(1, 0, 64'h100, 0, 64'hDEADBEEF);
    @(negedge clk);
    check("if_rd_hold", a_if_rdata, 64'h00A00093);

    n = cyc;
    a_if_addr = 64'h40;
    a_dm_addr = 64'h100;
    a_dm_we   = 1'b0;
    a_if_req  = 1'b1;
    a_dm_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.dm   = k[0];
      e.data = k[0] ? 64'hDEADBEEF : 64'h00A00093;
      e.cyc  = n + 2 + 3 * k;
      qa.push_back(e);
    end
    for (int i = 0; i < 30 && cyc < n + 11; i++) @(negedge clk);
    a_if_req = 1'b0;
    a_dm_req = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_done", 64'(qa.size()), 64'h0);

    n = cyc;
    e.dm = 1'b1; e.data = 64'hDEADBEEF; e.cyc = n + 2;
    qa.push_back(e);
    a_dm_req  = 1'b1;
    a_dm_we   = 1'b0;
    a_dm_addr = 64'h100;
    @(negedge clk);
    a_dm_req  = 1'b0;
    a_dm_addr = 64'h40;
    repeat (4) @(negedge clk);
    check("drop_done", 64'(qa.size()), 64'h0);

    a_dm_req   = 1'b1;
    a_dm_we    = 1'b1;
    a_dm_addr  = 64'h08;
    a_dm_wdata = 64'h1234;
    @(posedge clk);
    #2;
    check("abort_wr_on", 64'(a_mem_wr), 64'h1);
    rst_n    = 1'b0;
    a_dm_req = 1'b0;
    a_dm_we  = 1'b0;
    #1;
    check("abort_wr_off", 64'(a_mem_wr), 64'h0);
    check("abort_busy", 64'(a_busy), 64'h0);
    check("abort_ack", 64'(a_dm_ack), 64'h0);
    check("abort_dm_rd", a_dm_rdata, 64'h0);
    repeat (3) @(negedge clk);
    check("abort_mem", mem_a[1], 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    issue_a(0, 0, 64'h40, 0, 64'h00A00093);
    @(negedge clk);
    check("abort_wr_cnt", 64'(wr_cnt), 64'h1);

    n = cyc;
    e.dm = 1'b1; e.data = 64'h00000200_C0FFEE00; e.cyc = n + 4;
    qb.push_back(e);
    b_dm_req  = 1'b1;
    b_dm_we   = 1'b0;
    b_dm_addr = 64'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_busy", 64'(b_busy), 64'h1);
    end
    b_dm_req = 1'b0;
    @(negedge clk);
    check("b_idle", 64'(b_busy), 64'h0);

    repeat (5) @(negedge clk);
    check("qa_empty", 64'(qa.size()), 64'h0);
    check("qb_empty", 64'(qb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
